pipeline_ctrl: RTL and testbench

Sequencer for the 5-stage CPU pipeline's stall and flush controls. It consumes the data-hazard flag and the ID-stage call/ret/branch decodes, and drives the PC and pipeline-register enables. It holds fetch frozen while a control transfer is outstanding and pulses the matching hazard-clear line when the transfer resolves. Two saturating performance counters (data-stall cycles and control-wait cycles) are kept for bring-up.

---
 rtl/pipeline_ctrl_if.sv | 45 ++++
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline/hazard unit and the stall/flush sequencer.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    // Hazard and decode inputs to the sequencer
    logic             data_hazard;
    logic             mem_busy;
    logic             call;
    logic             ret;
    logic             branch;
    logic             call_resolved;
    logic             branch_resolved;
    logic             ret_resolved;

    // Pipeline enables, clear pulses and status from the sequencer
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             clr_call_haz;
    logic             clr_ret_haz;
    logic             clr_branch_haz;
    logic [1:0]       ctrl_state;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] ctrl_cnt;

    // Pipeline side: drives hazards/decodes, consumes enables
    modport master (
        output data_hazard, mem_busy, call, ret, branch,
               call_resolved, branch_resolved, ret_resolved,
        input  pc_we, ifid_we, ifid_flush, idex_bubble,
               clr_call_haz, clr_ret_haz, clr_branch_haz,
               ctrl_state, timeout_err, stall_cnt, ctrl_cnt
    );

    // Sequencer side
    modport slave (
        input  data_hazard, mem_busy, call, ret, branch,
               call_resolved, branch_resolved, ret_resolved,
        output pc_we, ifid_we, ifid_flush, idex_bubble,
               clr_call_haz, clr_ret_haz, clr_branch_haz,
               ctrl_state, timeout_err, stall_cnt, ctrl_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freezes fetch while a
// call/ret/branch is outstanding, pulses the matching hazard clear on
// resolution, forces recovery after WAIT_MAX cycles, and keeps two
// saturating bring-up counters.
module pipeline_ctrl #(
    parameter int unsigned WAIT_MAX = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_ctrl_if.slave pc_bus
);

    localparam int unsigned WAIT_W  = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_BR   = 2'd1,
        WAIT_CALL = 2'd2,
        WAIT_RET  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  ctrl_cnt_q, ctrl_cnt_d;
    logic              timeout_q, timeout_d;

    logic mem_busy_c;
    logic data_hazard_c;
    logic match_c;
    logic expired_c;
    logic pc_we_c;
    logic ifid_we_c;
    logic ifid_flush_c;
    logic idex_bubble_c;
    logic clr_call_c;
    logic clr_ret_c;
    logic clr_branch_c;

    // Inputs are masked during reset so the enables read as idle RUN
    assign mem_busy_c    = rst & pc_bus.mem_busy;
    assign data_hazard_c = rst & pc_bus.data_hazard;

    // Only the resolve that matches the outstanding transfer counts
    always_comb begin
        match_c = 1'b0;
        unique case (state_q)
            WAIT_BR:   match_c = pc_bus.branch_resolved;
            WAIT_CALL: match_c = pc_bus.call_resolved;
            WAIT_RET:  match_c = pc_bus.ret_resolved;
            default:   match_c = 1'b0;
        endcase
    end

    assign expired_c = ~match_c & (wait_cnt_q == WAIT_LAST);

    // Next-state, counter updates and combinational pipeline controls
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        ctrl_cnt_d    = ctrl_cnt_q;
        timeout_d     = timeout_q;
        pc_we_c       = 1'b1;
        ifid_we_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        clr_call_c    = 1'b0;
        clr_ret_c     = 1'b0;
        clr_branch_c  = 1'b0;

        if (state_q == RUN) begin
            wait_cnt_d = '0;
            if (mem_busy_c) begin
                pc_we_c   = 1'b0;
                ifid_we_c = 1'b0;
            end else if (data_hazard_c) begin
                pc_we_c       = 1'b0;
                ifid_we_c     = 1'b0;
                idex_bubble_c = 1'b1;
                if (stall_cnt_q != CNT_MAX) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end else if (pc_bus.ret) begin
                state_d = WAIT_RET;
            end else if (pc_bus.call) begin
                state_d = WAIT_CALL;
            end else if (pc_bus.branch) begin
                state_d = WAIT_BR;
            end
        end else begin
            pc_we_c      = 1'b0;
            ifid_flush_c = 1'b1;
            if (!mem_busy_c && (ctrl_cnt_q != CNT_MAX)) begin
                ctrl_cnt_d = ctrl_cnt_q + CNT_W'(1);
            end
            if (match_c || expired_c) begin
                pc_we_c      = 1'b1;
                clr_branch_c = (state_q == WAIT_BR);
                clr_call_c   = (state_q == WAIT_CALL);
                clr_ret_c    = (state_q == WAIT_RET);
                state_d      = RUN;
                if (expired_c) begin
                    timeout_d = 1'b1;
                end
            end else if (!mem_busy_c) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
    end

    // State, wait counter, sticky error and performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            ctrl_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            ctrl_cnt_q  <= ctrl_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pc_bus.pc_we          = pc_we_c;
    assign pc_bus.ifid_we        = ifid_we_c;
    assign pc_bus.ifid_flush     = ifid_flush_c;
    assign pc_bus.idex_bubble    = idex_bubble_c;
    assign pc_bus.clr_call_haz   = clr_call_c;
    assign pc_bus.clr_ret_haz    = clr_ret_c;
    assign pc_bus.clr_branch_haz = clr_branch_c;
    assign pc_bus.ctrl_state     = state_q;
    assign pc_bus.timeout_err    = timeout_q;
    assign pc_bus.stall_cnt      = stall_cnt_q;
    assign pc_bus.ctrl_cnt       = ctrl_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: cycle-level reference model plus directed scenarios.
module tb_pipeline_ctrl;

    localparam int unsigned WAIT_MAX = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_SAT  = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding transfer kind (0 none, 1 br, 2 call, 3 ret)
    int m_pend   = 0;
    int m_waited = 0;
    int m_stall  = 0;
    int m_ctrl   = 0;
    int m_to     = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_resolved();
        case (m_pend)
            1:       return int'(bus.branch_resolved);
            2:       return int'(bus.call_resolved);
            3:       return int'(bus.ret_resolved);
            default: return 0;
        endcase
    endfunction

    function automatic int m_expired();
        return (m_pend != 0 && m_resolved() == 0 && m_waited == WAIT_MAX - 1) ? 1 : 0;
    endfunction

    // Advance the model once per clock edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = 0; m_waited = 0; m_stall = 0; m_ctrl = 0; m_to = 0;
        end else if (m_pend == 0) begin
            if (!bus.mem_busy && bus.data_hazard) begin
                m_stall = (m_stall < CNT_SAT) ? m_stall + 1 : m_stall;
            end else if (!bus.mem_busy) begin
                m_waited = 0;
                m_pend = bus.ret ? 3 : bus.call ? 2 : bus.branch ? 1 : 0;
            end
        end else begin
            int res, exp_t;
            res   = m_resolved();
            exp_t = m_expired();
            if (!bus.mem_busy) m_ctrl = (m_ctrl < CNT_SAT) ? m_ctrl + 1 : m_ctrl;
            if (res != 0 || exp_t != 0) begin
                m_pend = 0;
                if (exp_t != 0) m_to = 1;
            end else if (!bus.mem_busy) begin
                m_waited++;
            end
        end
    end

    // Compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        int e_pc, e_ifid, e_flush, e_bub, e_cb, e_cc, e_cr, fire;
        e_pc = 1; e_ifid = 1; e_flush = 0; e_bub = 0; e_cb = 0; e_cc = 0; e_cr = 0;
        if (rst) begin
            if (m_pend == 0) begin
                if (bus.mem_busy) begin
                    e_pc = 0; e_ifid = 0;
                end else if (bus.data_hazard) begin
                    e_pc = 0; e_ifid = 0; e_bub = 1;
                end
            end else begin
                fire    = (m_resolved() != 0 || m_expired() != 0) ? 1 : 0;
                e_flush = 1;
                e_pc    = fire;
                e_cb    = (m_pend == 1) ? fire : 0;
                e_cc    = (m_pend == 2) ? fire : 0;
                e_cr    = (m_pend == 3) ? fire : 0;
            end
        end
        chk("pc_we",          int'(bus.pc_we),          e_pc);
        chk("ifid_we",        int'(bus.ifid_we),        e_ifid);
        chk("ifid_flush",     int'(bus.ifid_flush),     e_flush);
        chk("idex_bubble",    int'(bus.idex_bubble),    e_bub);
        chk("clr_branch_haz", int'(bus.clr_branch_haz), e_cb);
        chk("clr_call_haz",   int'(bus.clr_call_haz),   e_cc);
        chk("clr_ret_haz",    int'(bus.clr_ret_haz),    e_cr);
        chk("ctrl_state",     int'(bus.ctrl_state),     rst ? m_pend : 0);
        chk("timeout_err",    int'(bus.timeout_err),    m_to);
        chk("stall_cnt",      int'(bus.stall_cnt),      m_stall);
        chk("ctrl_cnt",       int'(bus.ctrl_cnt),       m_ctrl);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // Directed scenarios with hand-computed expectations
    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.data_hazard = 0; bus.mem_busy = 0;
        bus.call = 0; bus.ret = 0; bus.branch = 0;
        bus.call_resolved = 0; bus.branch_resolved = 0; bus.ret_resolved = 0;

        // Reset held 3 cycles with noisy inputs, then idle
        bus.data_hazard = 1; bus.mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("rst_pc_we", int'(bus.pc_we), 1);
            chk("rst_bubble", int'(bus.idex_bubble), 0);
            cyc();
        end
        bus.data_hazard = 0; bus.mem_busy = 0;
        rst = 1'b1;
        mid();
        chk("idle_pc_we", int'(bus.pc_we), 1);
        chk("idle_ifid_we", int'(bus.ifid_we), 1);
        chk("idle_state", int'(bus.ctrl_state), 0);
        chk("idle_cnt", int'(bus.stall_cnt) + int'(bus.ctrl_cnt), 0);
        cyc();

        // Data stall masks a pending branch decode
        bus.data_hazard = 1; bus.branch = 1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("stall_bubble", int'(bus.idex_bubble), 1);
            chk("stall_pc_we", int'(bus.pc_we), 0);
            chk("stall_state", int'(bus.ctrl_state), 0);
            cyc();
        end
        bus.data_hazard = 0;
        mid();
        chk("unstall_pc_we", int'(bus.pc_we), 1);
        chk("stall_cnt3", int'(bus.stall_cnt), 3);
        chk("unstall_state", int'(bus.ctrl_state), 0);
        cyc();
        bus.branch = 0;
        mid();
        chk("wait_br_entry", int'(bus.ctrl_state), 1);
        cyc();
        bus.branch_resolved = 1;
        mid();
        chk("br_clr", int'(bus.clr_branch_haz), 1);
        cyc();
        bus.branch_resolved = 0;

        // Branch resolved in cycle 2
        do_reset();
        bus.branch = 1;
        mid();
        chk("br_c0_state", int'(bus.ctrl_state), 0);
        cyc();
        bus.branch = 0;
        mid();
        chk("br_c1_state", int'(bus.ctrl_state), 1);
        chk("br_c1_pc_we", int'(bus.pc_we), 0);
        chk("br_c1_clr", int'(bus.clr_branch_haz), 0);
        cyc();
        bus.branch_resolved = 1;
        mid();
        chk("br_c2_state", int'(bus.ctrl_state), 1);
        chk("br_c2_clr", int'(bus.clr_branch_haz), 1);
        chk("br_c2_pc_we", int'(bus.pc_we), 1);
        chk("br_c2_ctrl_cnt", int'(bus.ctrl_cnt), 1);
        cyc();
        bus.branch_resolved = 0;
        mid();
        chk("br_c3_state", int'(bus.ctrl_state), 0);
        chk("br_c3_ctrl_cnt", int'(bus.ctrl_cnt), 2);
        cyc();

        // ret wins over call; stray resolves are ignored
        bus.call = 1; bus.ret = 1;
        cyc();
        bus.call = 0; bus.ret = 0;
        mid();
        chk("prio_state", int'(bus.ctrl_state), 3);
        cyc();
        bus.call_resolved = 1; bus.branch_resolved = 1;
        mid();
        chk("stray_clr_call", int'(bus.clr_call_haz), 0);
        chk("stray_clr_ret", int'(bus.clr_ret_haz), 0);
        chk("stray_pc_we", int'(bus.pc_we), 0);
        cyc();
        bus.call_resolved = 0; bus.branch_resolved = 0;
        bus.ret_resolved = 1;
        mid();
        chk("ret_clr", int'(bus.clr_ret_haz), 1);
        chk("ret_no_call_clr", int'(bus.clr_call_haz), 0);
        cyc();
        bus.ret_resolved = 0;
        mid();
        chk("ret_done_state", int'(bus.ctrl_state), 0);
        cyc();

        // Call timeout after exactly WAIT_MAX cycles
        do_reset();
        bus.call = 1;
        cyc();
        bus.call = 0;
        for (int c = 1; c <= 8; c++) begin
            mid();
            chk("to_state", int'(bus.ctrl_state), 2);
            chk("to_clr_call", int'(bus.clr_call_haz), (c == 8) ? 1 : 0);
            chk("to_err_pre", int'(bus.timeout_err), 0);
            cyc();
        end
        mid();
        chk("to_state_run", int'(bus.ctrl_state), 0);
        chk("to_err", int'(bus.timeout_err), 1);
        chk("to_ctrl_cnt", int'(bus.ctrl_cnt), 8);
        repeat (3) cyc();
        mid();
        chk("to_err_sticky", int'(bus.timeout_err), 1);
        cyc();

        // mem_busy freezes wait and ctrl counters in WAIT_BR
        do_reset();
        mid();
        chk("err_cleared", int'(bus.timeout_err), 0);
        cyc();
        bus.branch = 1;
        cyc();
        bus.branch = 0;
        for (int c = 1; c <= 12; c++) begin
            bus.mem_busy = (c >= 3 && c <= 6);
            mid();
            chk("mb_state", int'(bus.ctrl_state), 1);
            chk("mb_clr_br", int'(bus.clr_branch_haz), (c == 12) ? 1 : 0);
            if (c >= 3 && c <= 7) chk("mb_ctrl_frozen", int'(bus.ctrl_cnt), 2);
            cyc();
        end
        bus.mem_busy = 0;
        mid();
        chk("mb_to_run", int'(bus.ctrl_state), 0);
        chk("mb_to_err", int'(bus.timeout_err), 1);
        chk("mb_ctrl_cnt", int'(bus.ctrl_cnt), 8);
        cyc();

        // Asynchronous reset in WAIT_BR
        do_reset();
        bus.branch = 1;
        cyc();
        bus.branch = 0;
        cyc();
        mid();
        chk("arst_pre_state", int'(bus.ctrl_state), 1);
        rst = 1'b0;
        #1;
        chk("arst_state", int'(bus.ctrl_state), 0);
        chk("arst_clr", int'(bus.clr_branch_haz), 0);
        chk("arst_pc_we", int'(bus.pc_we), 1);
        chk("arst_flush", int'(bus.ifid_flush), 0);
        cyc();
        rst = 1'b1;

        // Counter saturation and mem_busy priority in RUN
        bus.data_hazard = 1;
        repeat (18) cyc();
        bus.data_hazard = 0;
        mid();
        chk("stall_sat", int'(bus.stall_cnt), CNT_SAT);
        cyc();
        bus.call = 1;
        cyc();
        bus.call = 0;
        repeat (8) cyc();
        bus.ret = 1;
        cyc();
        bus.ret = 0;
        repeat (8) cyc();
        mid();
        chk("ctrl_sat", int'(bus.ctrl_cnt), CNT_SAT);
        chk("sat_state", int'(bus.ctrl_state), 0);
        cyc();
        bus.mem_busy = 1; bus.data_hazard = 1; bus.branch = 1;
        mid();
        chk("mb_run_pc_we", int'(bus.pc_we), 0);
        chk("mb_run_bubble", int'(bus.idex_bubble), 0);
        cyc();
        bus.mem_busy = 0; bus.data_hazard = 0; bus.branch = 0;
        mid();
        chk("mb_run_state", int'(bus.ctrl_state), 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
